data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - wait-stated word memory responder with request/response handshake
module data_memory_responder #(
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_error_o
);

  localparam int          AW        = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [31:0] DEPTH_W   = 32'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  // Storage is deliberately left out of reset so contents survive it
  logic [31:0] mem [MEMORY_DEPTH];

  logic [31:0]   word_idx;
  logic          access_err;
  logic [AW-1:0] mem_addr;
  logic          access_now;
  logic          mem_we;

  // Address decode: byte offset from the base, wrapping below it into a huge index
  assign word_idx   = (addr_q - BASE_ADDR) >> 2;
  assign access_err = (addr_q[1:0] != 2'b00) || (word_idx >= DEPTH_W);
  assign mem_addr   = word_idx[AW-1:0];
  assign access_now = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we     = access_now && write_q && !access_err;

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_error_o = error_q;

  // Next-state and capture logic for the IDLE -> WAIT -> RESP sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          error_d = access_err;
          rdata_d = (access_err || write_q) ? 32'd0 : mem[mem_addr];
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Store port, written only on the access edge of a valid store
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= wdata_q;
    end
  end

endmodule
